// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display driver: FSM states,
// active-low 7-segment patterns and the BCD work-register width helper.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/count_display_bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal
// nibbles blank the digit.
module bcd_to_7seg
    import count_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_driver.sv
// Captures a binary count, converts it to BCD by sequential double-dabble and
// scans the digits onto a multiplexed 7-seg bank. Optional: LEADING_ZERO_BLANK_EN.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int N           = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      count,
    input  logic              load,
    output logic              busy,
    output logic              valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output state_e            dbg_state
);

    localparam int W  = bcd_width(DIGITS);
    localparam int CW = $clog2(N + 1);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: a load is accepted on any rising edge where load=1 and
    // busy=0; while busy=1 loads are dropped, never queued.

    state_e          state, state_n;
    logic [N-1:0]    shreg;
    logic [W-1:0]    work, work_adj;
    logic [CW-1:0]   bit_cnt;
    logic [W-1:0]    disp;
    logic [RW-1:0]   refresh_cnt;
    logic [IW-1:0]   idx;
    logic [3:0]      digit;
    logic            lz_blank;
    logic [6:0]      dec_seg;
    logic [DIGITS-1:0] an_n;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = SHIFT;
            SHIFT:   if (bit_cnt == CW'(N - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Double-dabble correction applied before each shift.
    always_comb begin
        work_adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[d*4 +: 4] >= 4'd5) work_adj[d*4 +: 4] = work[d*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            work    <= '0;
            bit_cnt <= '0;
            disp    <= '0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= count;
                        work    <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {work, shreg} <= {work_adj, shreg} << 1;
                    bit_cnt       <= bit_cnt + 1'b1;
                end
                DONE: begin
                    disp  <= work;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Digit scan runs free of the conversion FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        digit    = '0;
        lz_blank = 1'b0;
        an_n     = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == idx) digit = disp[d*4 +: 4];
            an_n[d] = !(valid && (IW'(d) == idx));
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and all above it are zero; units never blank.
        lz_blank = (idx != '0);
        for (int d = 0; d < DIGITS; d++) begin
            if ((IW'(d) >= idx) && (disp[d*4 +: 4] != 4'd0)) lz_blank = 1'b0;
        end
`endif
    end

    bcd_to_7seg u_dec (
        .nibble (digit),
        .seg    (dec_seg)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= (valid && !lz_blank) ? dec_seg : SEG_BLANK;
            an  <= an_n;
        end
    end

endmodule
